// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
// Optional write-through read bypass is enabled by defining REGFILE_SB_WR_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef logic [DEPTH_DEF-1:0] pend_vec_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a registered popcount.
// Priority per bit: issue > flush > writeback > hold; bit 0 never pends.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [Depth-1:0] pend_d, pend_q;
  logic [ADDR_W:0]  cnt_d, cnt_q;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned a = 1; a < Depth; a++) begin
      if (iss_en && (iss_addr == ADDR_W'(a))) begin
        pend_d[a] = 1'b1;
      end else if (flush) begin
        pend_d[a] = 1'b0;
      end else if (wr_en && (wr_addr == ADDR_W'(a))) begin
        pend_d[a] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
  end

  // Count is taken from the next-state vector so it lands on the same edge as pending.
  always_comb begin
    cnt_d = '0;
    for (int unsigned a = 0; a < Depth; a++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[a]};
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending  = pend_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write port and a pending scoreboard.
// Define REGFILE_SB_WR_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [Depth-1:0]  pending;
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != Zero);

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .clrn     (clrn),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .pending  (pending),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int unsigned a = 0; a < Depth; a++) begin
        mem_q[a] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rdy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      rdy  = ~pending[addr];
`ifdef REGFILE_SB_WR_BYPASS_EN
      // Reset masks forwarding so outputs stay at their reset values while clrn is high.
      if (!clrn && wr_hit && (wr_addr == addr)) begin
        data = wr_data;
        rdy  = 1'b1;
      end
`else
      // Without forwarding the consumer waits for the array update on the next edge.
`endif
      if (addr == Zero) begin
        data = '0;
        rdy  = 1'b1;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_ready[k]                 = rdy;
  end

endmodule
